// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the datapath word and the request unit's state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/request_unit_if.sv
// Port bundle between the request unit and its memory/decode neighbours.
// Latency: n/a (wires only).
// Backpressure: n/a; ihit/dhit act as the memory-side ready indications.
interface request_unit_if #(
    parameter int CNT_W = 32
);
    import cpu_types_pkg::*;

    logic             ihit;
    logic             dhit;
    logic             dREN_in;
    logic             dWEN_in;
    logic             halt_in;
    word_t            alu_out;
    word_t            store_in;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    word_t            dmemaddr;
    word_t            dmemstore;
    logic             pc_en;
    logic             halted;
    logic             misalign;
    logic [CNT_W-1:0] stall_cnt;

    modport dut (
        input  ihit, dhit, dREN_in, dWEN_in, halt_in, alu_out, store_in,
        output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore,
               pc_en, halted, misalign, stall_cnt
    );

    modport tb (
        output ihit, dhit, dREN_in, dWEN_in, halt_in, alu_out, store_in,
        input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore,
               pc_en, halted, misalign, stall_cnt
    );

endinterface

// File: rtl/request_unit.sv
// Sequences instruction fetch and one data access per instruction; pulses pc_en on retire.
// Latency: non-memory instructions retire on the ihit cycle; loads/stores retire on the dhit cycle.
// Backpressure: waits in FETCH for ihit and in DATA for dhit, counting DATA wait cycles.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic        CLK,
    input logic        nRST,
    request_unit_if.dut ruif
);

    state_t           state;
    state_t           next_state;
    word_t            addr_q;
    word_t            store_q;
    logic             dren_q;
    logic             dwen_q;
    logic             misalign_q;
    logic [CNT_W-1:0] stall_q;

    logic             mem_op;
    logic             aligned;
    logic             fetch_take;
    logic             imem_c;
    logic             dren_c;
    logic             dwen_c;
    logic             pc_en_c;

    assign mem_op     = ruif.dREN_in | ruif.dWEN_in;
    assign aligned    = (ruif.alu_out[1:0] == 2'b00);
    // A fetched instruction that is neither a halt nor gated by a missing ihit
    assign fetch_take = (state == FETCH) && ruif.ihit && !ruif.halt_in;

    // State register; async reset returns to FETCH so a pending data request drops at once
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and request/retire decode
    always_comb begin
        next_state = state;
        imem_c     = 1'b0;
        dren_c     = 1'b0;
        dwen_c     = 1'b0;
        pc_en_c    = 1'b0;
        case (state)
            FETCH: begin
                imem_c = 1'b1;
                if (ruif.ihit) begin
                    if (ruif.halt_in) begin
                        next_state = HALT;
                    end else if (mem_op) begin
                        next_state = aligned ? DATA : HALT;
                    end else begin
                        pc_en_c = 1'b1;
                    end
                end
            end
            DATA: begin
                // Driven purely from the latched copy so live decode changes cannot leak out
                dren_c = dren_q;
                dwen_c = dwen_q;
                if (ruif.dhit) begin
                    pc_en_c    = 1'b1;
                    next_state = FETCH;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // Capture the data access of an aligned load/store; a simultaneous read+write is a store
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q  <= '0;
            store_q <= '0;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
        end else if (fetch_take && mem_op && aligned) begin
            addr_q  <= ruif.alu_out;
            store_q <= ruif.store_in;
            dren_q  <= ruif.dREN_in & ~ruif.dWEN_in;
            dwen_q  <= ruif.dWEN_in;
        end
    end

    // Sticky flag recording that the halt came from a misaligned data address
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            misalign_q <= 1'b0;
        end else if (fetch_take && mem_op && !aligned) begin
            misalign_q <= 1'b1;
        end
    end

    // Count cycles spent waiting for dhit, saturating at all-ones
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
        end else if ((state == DATA) && !ruif.dhit && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign ruif.imemREN   = imem_c;
    assign ruif.dmemREN   = dren_c;
    assign ruif.dmemWEN   = dwen_c;
    assign ruif.dmemaddr  = addr_q;
    assign ruif.dmemstore = store_q;
    // Nothing retires while reset is held, even if ihit is asserted meanwhile
    assign ruif.pc_en     = pc_en_c & nRST;
    assign ruif.halted    = (state == HALT);
    assign ruif.misalign  = misalign_q;
    assign ruif.stall_cnt = stall_q;

endmodule

// File: tb/tb_request_unit.sv
module tb_request_unit;
    import cpu_types_pkg::*;

    localparam int CNT_W = 3;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic CLK;
    logic nRST;

    request_unit_if #(.CNT_W(CNT_W)) ruif ();

    request_unit #(.CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ruif (ruif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: an outstanding data access, a halt flag, a wait counter
    bit     m_pending;
    bit     m_halted;
    bit     m_mis;
    bit     m_rd;
    bit     m_wr;
    word_t  m_addr;
    word_t  m_data;
    longint m_cnt;

    task automatic model_reset();
        m_pending = 0; m_halted = 0; m_mis = 0; m_rd = 0; m_wr = 0;
        m_addr = '0; m_data = '0; m_cnt = 0;
    endtask

    initial model_reset();

    // Compare DUT outputs to the model mid-cycle, then advance the model for the coming edge
    always @(negedge CLK) begin
        logic e_imem, e_ren, e_wen, e_pc;
        if (!nRST) begin
            model_reset();
            chk("rst_imemREN", ruif.imemREN, 1'b1);
            chk("rst_pc_en", ruif.pc_en, 1'b0);
            chk("rst_dmemREN", ruif.dmemREN, 1'b0);
            chk("rst_dmemWEN", ruif.dmemWEN, 1'b0);
            chk("rst_halted", ruif.halted, 1'b0);
            chk("rst_stall", ruif.stall_cnt, 64'd0);
        end else begin
            e_imem = 0; e_ren = 0; e_wen = 0; e_pc = 0;
            if (!m_halted) begin
                if (m_pending) begin
                    e_ren = m_rd; e_wen = m_wr; e_pc = ruif.dhit;
                end else begin
                    e_imem = 1;
                    e_pc = ruif.ihit && !ruif.halt_in && !(ruif.dREN_in || ruif.dWEN_in);
                end
            end
            chk("m_imemREN", ruif.imemREN, e_imem);
            chk("m_dmemREN", ruif.dmemREN, e_ren);
            chk("m_dmemWEN", ruif.dmemWEN, e_wen);
            chk("m_pc_en", ruif.pc_en, e_pc);
            chk("m_halted", ruif.halted, m_halted);
            chk("m_misalign", ruif.misalign, m_mis);
            chk("m_stall_cnt", ruif.stall_cnt, m_cnt);
            chk("m_dmemaddr", ruif.dmemaddr, m_addr);
            chk("m_dmemstore", ruif.dmemstore, m_data);
            if (!m_halted) begin
                if (m_pending) begin
                    if (ruif.dhit) m_pending = 0;
                    else if (m_cnt < CNT_MAX) m_cnt++;
                end else if (ruif.ihit) begin
                    if (ruif.halt_in) begin
                        m_halted = 1;
                    end else if (ruif.dREN_in || ruif.dWEN_in) begin
                        if (ruif.alu_out % 4 != 0) begin
                            m_halted = 1; m_mis = 1;
                        end else begin
                            m_pending = 1;
                            m_addr = ruif.alu_out;
                            m_data = ruif.store_in;
                            m_wr = ruif.dWEN_in;
                            m_rd = ruif.dREN_in && !ruif.dWEN_in;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ih, input logic dh, input logic rd, input logic wr,
                         input logic hl, input word_t a, input word_t s);
        ruif.ihit = ih; ruif.dhit = dh; ruif.dREN_in = rd; ruif.dWEN_in = wr;
        ruif.halt_in = hl; ruif.alu_out = a; ruif.store_in = s;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic apply_reset();
        idle();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        #2;
        chk("reset_imemREN", ruif.imemREN, 1'b1);
        chk("reset_pc_en_gated", ruif.pc_en, 1'b0);
        chk("reset_dmemaddr", ruif.dmemaddr, 64'h0);
        idle();
        step();
        nRST = 1'b1;

        // R-type retires on the ihit cycle and stays in fetch
        drive(1, 0, 0, 0, 0, 32'h0000_0010, 32'h0);
        #1;
        chk("rtype_pc_en", ruif.pc_en, 1'b1);
        chk("rtype_imemREN", ruif.imemREN, 1'b1);
        step();
        // dhit outside DATA is ignored
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("fetch_dhit_pc_en", ruif.pc_en, 1'b0);
        step();

        // Load 0x104 with three stall cycles
        apply_reset();
        drive(1, 0, 1, 0, 0, 32'h0000_0104, 32'h0);
        #1;
        chk("load_issue_pc_en", ruif.pc_en, 1'b0);
        step();
        drive(1, 0, 0, 0, 0, 32'h0000_0FF0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("load_wait_ren", ruif.dmemREN, 1'b1);
            chk("load_wait_addr", ruif.dmemaddr, 64'h104);
            step();
        end
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("load_done_ren", ruif.dmemREN, 1'b1);
        chk("load_done_pc_en", ruif.pc_en, 1'b1);
        step();
        idle();
        #1;
        chk("load_stall_cnt", ruif.stall_cnt, 64'd3);
        chk("load_back_fetch", ruif.imemREN, 1'b1);
        step();

        // Store: decode inputs change during DATA, latched copy must hold
        drive(1, 0, 0, 1, 0, 32'h0000_0200, 32'hCAFE_0001);
        step();
        drive(0, 0, 1, 0, 0, 32'hDEAD_BEEC, 32'h1111_1111);
        #1;
        chk("store_addr_held", ruif.dmemaddr, 64'h200);
        chk("store_wen", ruif.dmemWEN, 1'b1);
        chk("store_data_held", ruif.dmemstore, 64'hCAFE_0001);
        chk("store_no_ren", ruif.dmemREN, 1'b0);
        step();
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        step();

        // Read+write together is a store
        drive(1, 0, 1, 1, 0, 32'h0000_0308, 32'h0000_ABCD);
        step();
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("rw_ren_cleared", ruif.dmemREN, 1'b0);
        chk("rw_wen", ruif.dmemWEN, 1'b1);
        chk("rw_ihit_ignored", ruif.pc_en, 1'b0);
        step();
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        step();

        // Saturation of the wait counter
        apply_reset();
        drive(1, 0, 1, 0, 0, 32'h0000_0040, 32'h0);
        step();
        idle();
        for (int i = 0; i < 10; i++) step();
        #1;
        chk("sat_stall_cnt", ruif.stall_cnt, CNT_MAX);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        step();
        idle();
        step();

        // Misaligned load halts with no data request
        apply_reset();
        drive(1, 0, 1, 0, 0, 32'h0000_0102, 32'h0);
        #1;
        chk("mis_pc_en", ruif.pc_en, 1'b0);
        step();
        drive(1, 1, 1, 0, 0, 32'h0000_0100, 32'h0);
        #1;
        chk("mis_halted", ruif.halted, 1'b1);
        chk("mis_flag", ruif.misalign, 1'b1);
        chk("mis_no_ren", ruif.dmemREN, 1'b0);
        step();
        step();

        // Halt wins over a store on the same fetch
        apply_reset();
        drive(1, 0, 0, 1, 1, 32'h0000_0300, 32'h5555_5555);
        step();
        drive(1, 1, 0, 1, 0, 32'h0000_0300, 32'h0);
        #1;
        chk("halt_halted", ruif.halted, 1'b1);
        chk("halt_no_mis", ruif.misalign, 1'b0);
        chk("halt_no_wen", ruif.dmemWEN, 1'b0);
        chk("halt_no_imem", ruif.imemREN, 1'b0);
        step();
        step();

        // Asynchronous reset in the middle of DATA
        apply_reset();
        drive(1, 0, 1, 0, 0, 32'h0000_0020, 32'h0);
        step();
        idle();
        step();
        #1;
        chk("arst_pre_ren", ruif.dmemREN, 1'b1);
        nRST = 1'b0;
        #1;
        chk("arst_ren_drop", ruif.dmemREN, 1'b0);
        chk("arst_imemREN", ruif.imemREN, 1'b1);
        step();
        nRST = 1'b1;
        #1;
        chk("arst_stall_zero", ruif.stall_cnt, 64'd0);
        chk("arst_fetch", ruif.imemREN, 1'b1);
        chk("arst_addr_zero", ruif.dmemaddr, 64'h0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 Parameter: CNT_W, 32, width of stall-cycle counter.
REQ-002 CLK  in  1  system clock; all state on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 ihit  in  1  instruction memory response valid this cycle.
REQ-005 dhit  in  1  data memory response valid this cycle.
REQ-006 dREN_in  in  1  decoded load of current instruction.
REQ-007 dWEN_in  in  1  decoded store of current instruction.
REQ-008 halt_in  in  1  decoded halt of current instruction.
REQ-009 alu_out  in  word_t  ALU result, used as data address.
REQ-010 store_in  in  word_t  store data from register file.
REQ-011 imemREN  out  1  instruction fetch request.
REQ-012 dmemREN / dmemWEN  out  1 each  data read / write request.
REQ-013 dmemaddr / dmemstore  out  word_t  latched data address / store data.
REQ-014 pc_en  out  1  one-cycle pulse: retire instruction, advance PC, allow regfile write.
REQ-015 halted  out  1  sticky halt indication.
REQ-016 misalign  out  1  sticky: halt caused by non-word-aligned data access.
REQ-017 stall_cnt  out  CNT_W  count of cycles spent waiting in DATA.

Function
REQ-018 FSM states FETCH, DATA, HALT; reset state FETCH.
REQ-019 FETCH: imemREN=1, dmemREN=dmemWEN=0; no ihit -> stay, pc_en=0.
REQ-020 FETCH, ihit, halt_in -> HALT, pc_en=0 (halt has priority over load/store).
REQ-021 FETCH, ihit, (dREN_in|dWEN_in), alu_out[1:0]!=0 -> HALT, misalign set next cycle, pc_en=0.
REQ-022 FETCH, ihit, (dREN_in|dWEN_in), aligned -> latch alu_out, store_in, dREN_in, dWEN_in; go DATA; pc_en=0.
REQ-023 FETCH, ihit, no memory op, no halt -> pc_en=1 same cycle, stay FETCH.
REQ-024 dREN_in and dWEN_in both high: treated as store only; latched read flag cleared.
REQ-025 DATA: imemREN=0; dmemREN/dmemWEN/dmemaddr/dmemstore driven only from latched registers, insensitive to input changes.
REQ-026 DATA, no dhit -> stay, stall_cnt += 1, saturating at all-ones.
REQ-027 DATA, dhit -> pc_en=1 same cycle, go FETCH; that cycle not counted.
REQ-028 dhit in FETCH and ihit in DATA are ignored.
REQ-029 HALT: all requests 0, pc_en=0, halted=1; absorbing until nRST.
REQ-030 pc_en is never high for two consecutive cycles of one instruction; exactly one pulse per retired instruction.

Reset
REQ-031 nRST low asynchronously forces: state FETCH, latched address/data/flags 0, halted=0, misalign=0, stall_cnt=0.
REQ-032 Reset mid-DATA drops dmemREN/dmemWEN immediately, without waiting for CLK or dhit.
REQ-033 Outputs during reset: imemREN=1 (state FETCH), all other outputs 0.

Structure
REQ-034 word_t and a state enum (FETCH, DATA, HALT) in cpu_types_pkg; no local redefinition.
REQ-035 Ports bundled in request_unit_if.vh with modports dut and tb, mirroring existing interface style.
REQ-036 Single module, no sub-modules; stall counter inline.

Verification
REQ-037 R-type: ihit=1, no mem op -> pc_en=1 same cycle, imemREN stays 1, state FETCH.
REQ-038 Load: ihit, dREN_in=1, alu_out=0x0000_0104; 3 cycles no dhit then dhit -> dmemREN=1, dmemaddr=0x104 for 4 cycles, pc_en pulses on dhit cycle, stall_cnt=3.
REQ-039 Store with alu_out changed to 0xDEAD_BEEC during DATA -> dmemaddr holds original latched value, dmemWEN=1, dmemstore unchanged.
REQ-040 Misaligned load alu_out=0x0000_0102 -> halted=1, misalign=1, no dmemREN ever asserted, pc_en=0.
REQ-041 halt_in with dWEN_in on same ihit -> HALT, dmemWEN never asserted; further ihit/dhit ignored.
REQ-042 nRST low in DATA between edges -> dmemREN falls before next CLK; after release, FETCH with stall_cnt=0.
